instruction_fetch: RTL
======================

# instruction_fetch

Fetch front end that drives the synchronous instruction memory's address port and consumes its read data one cycle later. It sequences the program counter, tracks the single in-flight read, and buffers returned words in a 2-entry queue that feeds decode with a valid/ready handshake. Redirects from execute (branch/jump) flush all queued and in-flight fetches. Out-of-range or misaligned fetch addresses halt fetch with a fault.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- MEM_BYTES, 1024, instruction memory size in bytes; the last legal word address is MEM_BYTES-4

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  32  byte address to the instruction memory; equals fetch_pc
- imem_data  in  32  memory read data, valid the cycle after the address was sampled
- redirect_valid  in  1  one-cycle pulse: flush and refetch from redirect_pc
- redirect_pc  in  32  redirect target
- out_valid  out  1  queue head holds an instruction
- out_ready  in  1  decode accepts the head this cycle
- out_instr  out  32  head instruction word
- out_pc  out  32  head instruction address
- fault  out  1  fetch halted on an illegal address
- fault_pc  out  32  address that caused the fault

## Operation
- States: RUN, HALT. Reset enters RUN.
- Legal address: fetch_pc[1:0]==0 and fetch_pc <= MEM_BYTES-4.
- pop = out_valid & out_ready. An issue is allowed when count + pend_valid - pop < 2, where count is the number of queue entries (0..2).
- Issue in RUN when the issue is allowed, redirect_valid=0, and fetch_pc is legal. On issue: pend_valid<=1, pend_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
- When the issue is not allowed or not taken, fetch_pc holds and pend_valid<=0.
- When pend_valid=1, push {pend_pc, imem_data} at the queue tail on the same edge.
- The queue is 2-entry in-order storage. Push and pop may occur in the same cycle. Push into a full queue is impossible by construction; the bench asserts on it.
- Fault: in RUN with fetch_pc illegal and redirect_valid=0:
  - state<=HALT, fault<=1, fault_pc<=fetch_pc, no issue.
  - In HALT the queue keeps draining normally.
- Redirect (priority over everything):
  - Queue cleared, pend_valid<=0 (the in-flight word is discarded), fetch_pc<=redirect_pc, no issue that cycle.
  - State<=RUN and fault<=0; fault_pc holds its value.
  - A misaligned or out-of-range target faults on the following cycle through the normal fault rule.
- fetch_pc+4 wraps mod 2^32, but the range check halts fetch before any wrap.

## Timing
- Reset values: fetch_pc=RESET_PC (so imem_addr=RESET_PC during reset), pend_valid=0, count=0, out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0, state=RUN.
- Reset applies asynchronously and can arrive mid-stream; all in-flight and queued data is lost.
- out_* come from registered queue storage, with no combinational path from out_ready to out_*. imem_addr comes from a register.
- Fetch latency: address issued at edge N; data pushed at edge N+1; out_valid high after N+1. The first issue is the first edge with rst_n high.
- Steady state with out_ready=1: one instruction per cycle, no bubbles.
- Redirect sampled at edge R: out_valid=0 after R, target issued at R+1, target at the head after R+2.
- Stall: out_*, count and fetch_pc remain stable while out_valid=1 and out_ready=0 with the queue full.

## Test plan
- Reset with RESET_PC=0 and memory words 0x1000+i, out_ready=1 -> out_valid rises 2 edges after reset release, then out_pc=0,4,8,... on consecutive cycles with out_instr=0x1000,0x1001,...
- out_ready=0 for 6 cycles mid-stream at pc 0x20 -> out_pc=0x20 stable, count=2, fetch_pc=0x28 held. On release -> 0x20,0x24,0x28 with no gap or duplicate.
- Redirect to 0x80 with the queue full and a read in flight -> out_valid=0 the next cycle, then out_pc=0x80 after 2 more edges. Stale 0x2x words are never presented.
- Sequential run with MEM_BYTES=1024 -> 0x3FC delivered, then fault=1, fault_pc=0x400, no further issue, out_valid falls once the queue drains.
- Redirect to 0x42 -> fault=1, fault_pc=0x42. Then redirect to 0x10 -> fault=0, out_pc=0x10 after 2 edges.
- rst_n asserted asynchronously mid-stream with out_ready=0 -> out_valid=0, out_pc=0, out_instr=0, fault=0 immediately. After release, refetch from RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: program-counter sequencing with one in-flight synchronous imem read,
// a 2-entry in-order fetch queue toward decode, redirect flush and illegal-address halt.
`default_nettype none

module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] fetch_pc;
  logic        pend_valid;
  logic [31:0] pend_pc;
  logic [1:0]  count;
  logic [31:0] tail_pc;
  logic [31:0] tail_instr;

  logic        pop;
  logic        pc_legal;
  logic        room;
  logic        issue;
  logic        fault_hit;
  logic [1:0]  count_after_pop;
  logic [2:0]  occ_after_pop;

  assign imem_addr = fetch_pc;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign pc_legal  = (fetch_pc[1:0] == 2'b00) && (fetch_pc <= LAST_PC);

  // A new read may only start if its word is guaranteed a free slot when it returns.
  assign count_after_pop = count - {1'b0, pop};
  assign occ_after_pop   = {1'b0, count_after_pop} + {2'b00, pend_valid};
  assign room            = (occ_after_pop < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    fault_hit  = 1'b0;
    if (redirect_valid) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (!pc_legal) begin
            fault_hit  = 1'b1;
            state_next = HALT;
          end else if (room) begin
            issue = 1'b1;
          end
        end
        HALT:    state_next = HALT;
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= 32'h0;
      count      <= 2'd0;
      out_pc     <= 32'h0;
      out_instr  <= 32'h0;
      tail_pc    <= 32'h0;
      tail_instr <= 32'h0;
      fault      <= 1'b0;
      fault_pc   <= 32'h0;
    end else if (redirect_valid) begin
      fetch_pc   <= redirect_pc;
      pend_valid <= 1'b0;
      count      <= 2'd0;
      fault      <= 1'b0;
    end else begin
      pend_valid <= issue;
      if (issue) begin
        pend_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (fault_hit) begin
        fault    <= 1'b1;
        fault_pc <= fetch_pc;
      end
      if (pop && (count == 2'd2)) begin
        out_pc    <= tail_pc;
        out_instr <= tail_instr;
      end
      // The returning word lands in whichever slot is first free after this cycle's pop.
      if (pend_valid) begin
        if (count_after_pop == 2'd0) begin
          out_pc    <= pend_pc;
          out_instr <= imem_data;
        end else begin
          tail_pc    <= pend_pc;
          tail_instr <= imem_data;
        end
      end
      count <= count_after_pop + {1'b0, pend_valid};
    end
  end

endmodule

`default_nettype wire
